// File: rtl/shift_sequencer.sv
// shift_sequencer: two-requester command front end for a shared
// universal shift register, sequencing shifts one bit per clock.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld0,
  input  logic             vld1,
  output logic             rdy0,
  output logic             rdy1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             sin0,
  input  logic             sin1,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_SR   = 2'd1;
  localparam logic [1:0] OP_SL   = 2'd2;
  localparam logic [1:0] OP_LD   = 2'd3;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] data_r;
  logic             sin_r;
  logic             owner;
  logic             last_grant;

  logic             gnt0;
  logic             gnt1;
  logic             take;
  logic             sel;
  logic [1:0]       op_s;
  logic [AMT_W-1:0] amt_s;
  logic [AMT_W-1:0] amt_c;
  logic [WIDTH-1:0] data_s;
  logic             sin_s;
  logic             is_shift;

  // Round-robin grant: on a tie, favour the requester not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (vld0 && vld1) begin
      gnt0 = last_grant;
      gnt1 = !last_grant;
    end else begin
      gnt0 = vld0;
      gnt1 = vld1;
    end
  end

  assign take   = rst && (state == IDLE) && (vld0 || vld1);
  assign rdy0   = take && gnt0;
  assign rdy1   = take && gnt1;
  assign sel    = gnt1;
  assign op_s   = sel ? op1   : op0;
  assign amt_s  = sel ? amt1  : amt0;
  assign data_s = sel ? data1 : data0;
  assign sin_s  = sel ? sin1  : sin0;
  assign amt_c  = (amt_s > AMT_MAX) ? AMT_MAX : amt_s;

  assign is_shift = ((op_r == OP_SR) || (op_r == OP_SL))
                    && (cnt != '0);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign done_id = done && owner;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state: stay in EXEC until the last pending shift.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take) state_nx = EXEC;
      EXEC: begin
        if (!(is_shift && (cnt > AMT_ONE)))
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command capture, arbitration history and the shift datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q          <= '0;
      sout       <= 1'b0;
      cnt        <= '0;
      op_r       <= OP_HOLD;
      data_r     <= '0;
      sin_r      <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (take) begin
      op_r       <= op_s;
      cnt        <= amt_c;
      data_r     <= data_s;
      sin_r      <= sin_s;
      owner      <= sel;
      last_grant <= sel;
    end else if (state == EXEC) begin
      unique case (op_r)
        OP_LD: q <= data_r;
        OP_SR: begin
          if (is_shift) begin
            q    <= {sin_r, q[WIDTH-1:1]};
            sout <= q[0];
            cnt  <= cnt - AMT_ONE;
          end
        end
        OP_SL: begin
          if (is_shift) begin
            q    <= {q[WIDTH-2:0], sin_r};
            sout <= q[WIDTH-1];
            cnt  <= cnt - AMT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench; expected done events are
// queued at acceptance and retired when done pulses.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic       rdy0, rdy1;
  logic [1:0] op0 = '0, op1 = '0;
  logic [2:0] amt0 = '0, amt1 = '0;
  logic [3:0] data0 = '0, data1 = '0;
  logic       sin0 = 1'b0, sin1 = 1'b0;
  logic [3:0] q;
  logic       sout, busy, done, done_id;

  typedef struct {
    int         cyc;
    logic       id;
    logic [3:0] q;
    logic       sout;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [3:0] mq = '0;
  logic       msout = 1'b0;

  shift_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .vld0(vld0), .vld1(vld1),
    .rdy0(rdy0), .rdy1(rdy1),
    .op0(op0), .op1(op1),
    .amt0(amt0), .amt1(amt1),
    .data0(data0), .data1(data1),
    .sin0(sin0), .sin1(sin1),
    .q(q), .sout(sout), .busy(busy),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Retire one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("done_cyc", cyc, mon_e.cyc);
        check("done_id", done_id, mon_e.id);
        check("done_q", q, mon_e.q);
        check("done_sout", sout, mon_e.sout);
      end
    end
  end

  // Reference behaviour of one command; returns N.
  function automatic int model(input logic [1:0] op,
                               input logic [2:0] amt,
                               input logic [3:0] d,
                               input logic s);
    int n;
    n = (amt > 3'd4) ? 4 : int'(amt);
    case (op)
      2'd3: mq = d;
      2'd1: for (int i = 0; i < n; i++) begin
        msout = mq[0];
        mq = {s, mq[3:1]};
      end
      2'd2: for (int i = 0; i < n; i++) begin
        msout = mq[3];
        mq = {mq[2:0], s};
      end
      default: ;
    endcase
    if (op == 2'd0 || op == 2'd3 || n == 0) n = 1;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    sbq.delete();
    mq = '0;
    msout = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Present a command at a negedge and return just after its accept edge.
  task automatic issue(input bit r, input logic [1:0] op,
                       input logic [2:0] amt, input logic [3:0] d,
                       input logic s);
    int   n;
    bit   ok;
    exp_t e;
    @(negedge clk);
    if (r) begin
      op1 = op; amt1 = amt; data1 = d; sin1 = s; vld1 = 1'b1;
    end else begin
      op0 = op; amt0 = amt; data0 = d; sin0 = s; vld0 = 1'b1;
    end
    #1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((r ? rdy1 : rdy0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      vld0 = 1'b0;
      vld1 = 1'b0;
      return;
    end
    check("rdy_other", r ? rdy0 : rdy1, 0);
    n      = model(op, amt, d, s);
    e.cyc  = cyc + 1 + n;
    e.id   = r;
    e.q    = mq;
    e.sout = msout;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int   g;
    bit   ok;
    exp_t e;

    // Reset with a pending request.
    vld0 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy0", rdy0, 0);
    check("rst_q", q, 4'b0000);
    check("rst_sout", sout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    #1;
    check("post_rst_rdy0", rdy0, 1);
    vld0 = 1'b0;

    // Load then shift right by 2 with sin=1.
    issue(0, 2'd3, 3'd0, 4'b1011, 1'b0);
    wait_idle();
    issue(0, 2'd1, 3'd2, 4'b0000, 1'b1);
    @(negedge clk);
    check("sr_hold_q", q, 4'b1011);
    @(negedge clk);
    check("sr1_q", q, 4'b1101);
    check("sr1_sout", sout, 1);
    check("sr1_busy", busy, 1);
    @(negedge clk);
    check("sr2_q", q, 4'b1110);
    check("sr2_sout", sout, 1);
    check("sr2_done", done, 1);
    wait_idle();

    // Shift left by 3 from requester 1.
    issue(0, 2'd3, 3'd0, 4'b1011, 1'b0);
    wait_idle();
    issue(1, 2'd2, 3'd3, 4'b0000, 1'b0);
    @(negedge clk);
    check("sl_busy_rdy", rdy1, 0);
    @(negedge clk);
    check("sl1_q", q, 4'b0110);
    check("sl1_sout", sout, 1);
    @(negedge clk);
    check("sl2_q", q, 4'b1100);
    check("sl2_sout", sout, 0);
    @(negedge clk);
    check("sl3_q", q, 4'b1000);
    check("sl3_sout", sout, 1);
    wait_idle();

    // Contention: hold commands from both, grants alternate.
    do_reset();
    op0 = 2'd0;
    op1 = 2'd0;
    vld0 = 1'b1;
    vld1 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (rdy0 || rdy1) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
      if (!ok) begin
        check("cont_timeout", 0, 1);
        break;
      end
      g = int'(rdy1);
      check("cont_grant", g, k % 2);
      check("cont_one_rdy", rdy0 & rdy1, 0);
      e.cyc  = cyc + 2;
      e.id   = rdy1;
      e.q    = mq;
      e.sout = msout;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    vld0 = 1'b0;
    vld1 = 1'b0;
    wait_idle();

    // Clamped shift (7 -> 4) and zero-length shift.
    issue(0, 2'd3, 3'd0, 4'b1011, 1'b0);
    wait_idle();
    issue(1, 2'd1, 3'd7, 4'b0000, 1'b0);
    wait_idle();
    check("clamp_q", q, 4'b0000);
    issue(0, 2'd3, 3'd0, 4'b1011, 1'b0);
    wait_idle();
    issue(0, 2'd1, 3'd0, 4'b0000, 1'b1);
    wait_idle();
    check("zero_q", q, 4'b1011);

    // Abort mid-shift, then a clean load.
    issue(1, 2'd1, 3'd4, 4'b0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_q", q, 4'b1101);
    rst = 1'b0;
    #1;
    sbq.delete();
    mq = '0;
    msout = 1'b0;
    check("abort_q", q, 4'b0000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sout", sout, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 2'd3, 3'd0, 4'b0101, 1'b0);
    wait_idle();
    check("after_abort_q", q, 4'b0101);
    check("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
